gate_checker2: RTL

GATE_CHECKER2 -- requirements
Module: gate_checker2

---
 rtl/gate_checker2.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/gate_checker2.sv
`default_nettype none
// ============================================================================
// Module      : gate_checker2
// Description : Exhaustive checker for a 2-input combinational gate. On start
//               it drives the four input vectors {b,a} = 00,01,10,11, holds
//               each for SETTLE cycles, samples the gate output at the end of
//               each hold and compares it against the EXPECT truth table.
//               Reports pass / mismatch count / per-vector fail mask and a
//               one-cycle done pulse when the run completes.
// Ports       : clk        - single clock, rising edge
//               rst        - synchronous active-high reset
//               start      - begin a run (only honoured while idle)
//               dut_y      - output of the gate under test
//               dut_a/b    - registered stimulus to the gate inputs
//               busy       - run in progress
//               done       - one-cycle pulse at end of run
//               pass       - last run had zero mismatches
//               err_count  - mismatch count of last run (0..4)
//               fail_mask  - bit k set if vector k mismatched
// Revision    : 1.0 - initial release
// ============================================================================
module gate_checker2 #(
  parameter logic [3:0] EXPECT = 4'b1000,
  parameter int         SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       dut_y,
  output logic       dut_a,
  output logic       dut_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  localparam logic       c_ST_IDLE   = 1'b0;
  localparam logic       c_ST_RUN    = 1'b1;
  localparam logic [3:0] c_LAST_WAIT = 4'(SETTLE - 1);

  logic       state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [3:0] wait_q, wait_d;
  logic       a_q, a_d;
  logic       b_q, b_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [2:0] err_q, err_d;
  logic [3:0] mask_q, mask_d;

  // A sample edge closes the hold window of the current vector.
  logic       w_sample;
  logic       w_last;
  logic       w_mismatch;
  logic [1:0] w_idx_nxt;

  assign w_sample   = (state_q == c_ST_RUN) && (wait_q == c_LAST_WAIT);
  assign w_last     = (idx_q == 2'd3);
  assign w_mismatch = (dut_y != EXPECT[idx_q]);
  assign w_idx_nxt  = idx_q + 2'd1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= c_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ST_IDLE: if (start) state_d = c_ST_RUN;
      c_ST_RUN:  if (w_sample && w_last) state_d = c_ST_IDLE;
      default:   state_d = c_ST_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    idx_d  = idx_q;
    wait_d = wait_q;
    a_d    = a_q;
    b_d    = b_q;
    busy_d = busy_q;
    done_d = 1'b0;
    pass_d = pass_q;
    err_d  = err_q;
    mask_d = mask_q;
    case (state_q)
      c_ST_IDLE: begin
        if (start) begin
          idx_d  = 2'd0;
          wait_d = 4'd0;
          a_d    = 1'b0;
          b_d    = 1'b0;
          busy_d = 1'b1;
          pass_d = 1'b0;
          err_d  = 3'd0;
          mask_d = 4'd0;
        end
      end
      c_ST_RUN: begin
        if (w_sample) begin
          if (w_mismatch) begin
            err_d         = err_q + 3'd1;
            mask_d[idx_q] = 1'b1;
          end
          wait_d = 4'd0;
          if (w_last) begin
            busy_d = 1'b0;
            done_d = 1'b1;
            a_d    = 1'b0;
            b_d    = 1'b0;
            // err_d already includes the final vector's result
            pass_d = (err_d == 3'd0);
          end else begin
            // next vector is launched on the same edge: no idle gap
            idx_d = w_idx_nxt;
            a_d   = w_idx_nxt[0];
            b_d   = w_idx_nxt[1];
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q  <= 2'd0;
      wait_q <= 4'd0;
      a_q    <= 1'b0;
      b_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      pass_q <= 1'b0;
      err_q  <= 3'd0;
      mask_q <= 4'd0;
    end else begin
      idx_q  <= idx_d;
      wait_q <= wait_d;
      a_q    <= a_d;
      b_q    <= b_d;
      busy_q <= busy_d;
      done_q <= done_d;
      pass_q <= pass_d;
      err_q  <= err_d;
      mask_q <= mask_d;
    end
  end

  assign dut_a     = a_q;
  assign dut_b     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_mask = mask_q;

endmodule
`default_nettype wire
